// File: rtl/issue_fetch_request_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// issue_fetch_request_arbiter_pkg
//   Shared issue-stage sizing constants used by the fetch request arbiter and
//   its round-robin picker.
//     ISSUE_WF_PER_CU    : wavefront slots per compute unit (bitmap width)
//     ISSUE_WF_ID_LENGTH : width of a wavefront id
// ---------------------------------------------------------------------------
package issue_fetch_request_arbiter_pkg;

  localparam int unsigned ISSUE_WF_PER_CU    = 40;
  localparam int unsigned ISSUE_WF_ID_LENGTH = 6;

endpackage : issue_fetch_request_arbiter_pkg

// File: rtl/issue_fetch_request_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// issue_rr_pick
//   Combinational round-robin priority pick. The search starts at the slot
//   after i_last_grant and wraps from N-1 back to 0; the first set request
//   bit wins.
//   Ports:
//     i_req        [N]   : request vector
//     i_last_grant [IDW] : most recently granted slot (must be < N)
//     o_found            : at least one request bit is set
//     o_winner     [IDW] : winning slot id (0 when !o_found)
// ---------------------------------------------------------------------------
module issue_rr_pick
  import issue_fetch_request_arbiter_pkg::*;
#(
  parameter int unsigned N   = ISSUE_WF_PER_CU,
  parameter int unsigned IDW = ISSUE_WF_ID_LENGTH
) (
  input  logic [N-1:0]   i_req,
  input  logic [IDW-1:0] i_last_grant,
  output logic           o_found,
  output logic [IDW-1:0] o_winner
);

  int unsigned    w_pos;
  logic [IDW-1:0] w_idx;

  always_comb begin
    o_found  = 1'b0;
    o_winner = '0;
    w_pos    = 0;
    w_idx    = '0;
    for (int unsigned k = 0; k < N; k++) begin
      // Offset k from last_grant+1, folded back into [0, N).
      w_pos = 32'(i_last_grant) + 32'd1 + k;
      if (w_pos >= N) begin
        w_pos = w_pos - N;
      end
      w_idx = IDW'(w_pos);
      if (!o_found && i_req[w_idx]) begin
        o_found  = 1'b1;
        o_winner = w_idx;
      end
    end
  end

endmodule : issue_rr_pick

// File: rtl/issue_fetch_request_arbiter.sv
// ---------------------------------------------------------------------------
// issue_fetch_request_arbiter
//   Latches per-wavefront "ready for next instruction" pulses as pending
//   requests and hands one wavefront per accepted transfer to fetch over a
//   registered valid/ready handshake, round-robin across wavefronts.
//   Optional feature macro: ISSUE_FETCH_ARB_DUP_DETECT_EN (sticky duplicate
//   request flag on dup_error; tied to 0 when undefined).
//   Ports:
//     clk                 : clock, rising edge
//     rst                 : asynchronous active-low reset
//     wave_valid_entries  : one-cycle request pulses, one bit per wavefront
//     flush_en/flush_wfid : drop the request of flush_wfid (ids >= WF_PER_CU ignored)
//     fetch_req_ready     : fetch accepts the current request
//     fetch_req_valid     : registered request valid
//     fetch_req_wfid      : registered requesting wavefront id
//     pending_bitmap      : latched requests not yet in the output register
//     dup_error           : sticky duplicate-request flag
// ---------------------------------------------------------------------------
module issue_fetch_request_arbiter
  import issue_fetch_request_arbiter_pkg::*;
#(
  parameter int unsigned WF_PER_CU    = ISSUE_WF_PER_CU,
  parameter int unsigned WF_ID_LENGTH = ISSUE_WF_ID_LENGTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [WF_PER_CU-1:0]    wave_valid_entries,
  input  logic                    flush_en,
  input  logic [WF_ID_LENGTH-1:0] flush_wfid,
  input  logic                    fetch_req_ready,
  output logic                    fetch_req_valid,
  output logic [WF_ID_LENGTH-1:0] fetch_req_wfid,
  output logic [WF_PER_CU-1:0]    pending_bitmap,
  output logic                    dup_error
);

  logic [WF_PER_CU-1:0]    r_pend;
  logic                    r_valid;
  logic [WF_ID_LENGTH-1:0] r_wfid;
  logic [WF_ID_LENGTH-1:0] r_last_grant;

  logic                    w_flush_ok;
  logic [WF_PER_CU-1:0]    w_flush_vec;
  logic [WF_PER_CU-1:0]    w_held_vec;
  logic [WF_PER_CU-1:0]    w_pulse_eff;
  logic [WF_PER_CU-1:0]    w_cand;
  logic [WF_PER_CU-1:0]    w_grant_vec;
  logic [WF_PER_CU-1:0]    w_pend_nxt;
  logic                    w_found;
  logic [WF_ID_LENGTH-1:0] w_winner;
  logic                    w_free;
  logic                    w_load;
  logic                    w_flush_held;

  // Flush decode; out-of-range ids select nothing.
  always_comb begin
    w_flush_ok  = flush_en && (32'(flush_wfid) < WF_PER_CU);
    w_flush_vec = w_flush_ok ? (WF_PER_CU'(1) << flush_wfid) : '0;
  end

  // A pulse for the wavefront already sitting in the output register is
  // absorbed; a pulse for one already pending merges into the same P bit.
  // The flushed bit is masked from both pending and same-cycle pulses.
  always_comb begin
    w_held_vec  = r_valid ? (WF_PER_CU'(1) << r_wfid) : '0;
    w_pulse_eff = wave_valid_entries & ~w_held_vec;
    w_cand      = (r_pend | w_pulse_eff) & ~w_flush_vec;
  end

  issue_rr_pick #(
    .N   (WF_PER_CU),
    .IDW (WF_ID_LENGTH)
  ) u_rr_pick (
    .i_req        (w_cand),
    .i_last_grant (r_last_grant),
    .o_found      (w_found),
    .o_winner     (w_winner)
  );

  always_comb begin
    w_free       = !r_valid || fetch_req_ready;
    w_load       = w_free && w_found;
    w_grant_vec  = w_load ? (WF_PER_CU'(1) << w_winner) : '0;
    w_pend_nxt   = w_cand & ~w_grant_vec;
    // Withdrawal only applies to a stalled request; an accepted one completes.
    w_flush_held = r_valid && !fetch_req_ready && w_flush_ok && (flush_wfid == r_wfid);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pend       <= '0;
      r_valid      <= 1'b0;
      r_wfid       <= '0;
      r_last_grant <= WF_ID_LENGTH'(WF_PER_CU - 1);
    end else begin
      r_pend <= w_pend_nxt;
      if (w_load) begin
        r_valid      <= 1'b1;
        r_wfid       <= w_winner;
        r_last_grant <= w_winner;
      end else if (w_free || w_flush_held) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign fetch_req_valid = r_valid;
  assign fetch_req_wfid  = r_wfid;
  assign pending_bitmap  = r_pend;

`ifdef ISSUE_FETCH_ARB_DUP_DETECT_EN
  logic r_dup;
  logic w_dup;

  assign w_dup = |(wave_valid_entries & (r_pend | w_held_vec));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_dup <= 1'b0;
    end else if (w_dup) begin
      r_dup <= 1'b1;
    end
  end

  assign dup_error = r_dup;
`else
  assign dup_error = 1'b0;
`endif

endmodule : issue_fetch_request_arbiter

// File: doc/issue_fetch_request_arbiter.md
# issue_fetch_request_arbiter

Consumes the per-wavefront "ready for next instruction" pulse bitmap (`wave_valid_entries`) produced by issue flow control. Latches those pulses as pending requests and round-robin selects one wavefront per accepted transfer toward fetch over a registered valid/ready handshake. Sits between the issue stage and the fetch/wavepool request port, one instance per CU.

## Interface
Parameters:
- `WF_PER_CU`, 40, number of wavefront slots (bitmap width)
- `WF_ID_LENGTH`, 6, width of a wavefront id

Ports:
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  reset, asynchronous assert, active-low
- `wave_valid_entries`  in  WF_PER_CU  one-cycle request pulses, one bit per wavefront
- `flush_en`  in  1  drop the pending request of `flush_wfid`
- `flush_wfid`  in  WF_ID_LENGTH  wavefront being flushed (halt/terminate)
- `fetch_req_ready`  in  1  fetch accepts the current request
- `fetch_req_valid`  out  1  request present, registered
- `fetch_req_wfid`  out  WF_ID_LENGTH  requesting wavefront, registered
- `pending_bitmap`  out  WF_PER_CU  latched, not yet issued requests (debug/tracemon)
- `dup_error`  out  1  sticky duplicate-request flag (only with macro, see Configuration)

## Operation
- Pending register P[WF_PER_CU]: bit set by a pulse, cleared when the wavefront is loaded into the output register or flushed.
- Candidate set C = (P | wave_valid_entries) with flushed bit masked off; the bypass lets a pulse win in the same cycle it arrives.
- Output register free when `!fetch_req_valid` or `fetch_req_valid & fetch_req_ready`. When free and C != 0: load the round-robin winner, set valid, clear that bit in P.
- Round-robin: search starts at last_grant+1, wraps from WF_PER_CU-1 to 0; last_grant updates only on load. Reset value of last_grant = WF_PER_CU-1 so the first search starts at 0.
- Ids >= WF_PER_CU on `flush_wfid` are ignored.
- Simultaneous pulse and load for the same wf: pulse was the load source, so P ends 0. A pulse for a wf already in P or held in the output register is absorbed (no second entry).
- Flush same cycle as a pulse for the same wf: flush wins, P bit 0.
- Flush matching a held (valid & !ready) output: valid drops next cycle; the only permitted withdrawal of a valid request. Flush matching an output that is accepted the same cycle: transfer completes; nothing dropped.
- States per wavefront: IDLE -> PENDING (pulse) -> OUTSTANDING (in output reg) -> IDLE (accept or flush).

## Timing
- Reset: `fetch_req_valid`=0, `fetch_req_wfid`=0, `pending_bitmap`=0, `dup_error`=0, last_grant=WF_PER_CU-1.
- Latency: pulse in cycle N with register free -> `fetch_req_valid`=1 with that id in cycle N+1.
- While valid & !ready, `fetch_req_valid` and `fetch_req_wfid` hold stable (except flush).
- Back-to-back: with ready held high and C nonempty, one grant per cycle, no bubble.
- `pending_bitmap` is the registered P (excludes the output-register entry).
- Reset mid-operation: all pending and held requests discarded immediately; no request is emitted until a new pulse arrives.

## Configuration
- `ISSUE_FETCH_ARB_DUP_DETECT_EN` defined: `dup_error` sets (sticky until reset) when a pulse hits a wf already in P or held in the output register; the request is still absorbed.
- Undefined: detection logic removed, `dup_error` tied to 0.

## Structure
- `WF_PER_CU`, `WF_ID_LENGTH` come from the shared issue defines package; no new typedefs.
- One sub-module, `issue_rr_pick`: combinational round-robin priority pick (request vector, last_grant -> found flag, winner id).
- Top contains P, the output register, last_grant, the flush decode and the optional duplicate-detect flag.

## Test plan
- Reset mid-stream with P=0x5 and a held request -> all outputs 0 the next cycle; P stays 0 afterwards.
- Pulse bit 3 at cycle N, ready=1 -> valid with wfid 3 at N+1; then `pending_bitmap`=0 and valid=0 at N+2.
- Pulses for bits 0, 5 and 39 at once, ready=1 -> grants 0, 5, 39 in consecutive cycles; then a pulse for bit 0 plus bit 2 -> grant order 0 before 2 (pointer wrapped after 39).
- Request for wfid 7 held with ready=0 for 4 cycles -> valid/wfid stable for the whole stall; ready=1 -> next pending id loads in the following cycle.
- Flush wfid 7 while held with ready=0 -> valid=0 next cycle. Flush wfid 9 in the same cycle as its pulse -> never issued.
- Macro on, pulse bit 4 twice while pending -> exactly one grant of 4 and `dup_error`=1 sticky. Macro off -> `dup_error`=0.
